// File: rtl/al4s3b_wb_arbiter.sv
// al4s3b_wb_arbiter
// Two-master round-robin Wishbone arbiter in front of the single FPGA slave
// port. A grant is held from CYC rise to CYC fall. A bus watchdog completes
// any strobe that the slave never acknowledges.
module al4s3b_wb_arbiter #(
   parameter int          TIMEOUT_CYCLES     = 16,
   parameter logic [31:0] TIMEOUT_READ_VALUE = 32'hBAD_FAB_AC
) (
   input  logic        WBs_CLK_i,
   input  logic        WBs_RST_i,
   input  logic [16:0] M0_ADR_i,
   input  logic        M0_CYC_i,
   input  logic        M0_STB_i,
   input  logic        M0_WE_i,
   input  logic [3:0]  M0_BYTE_STB_i,
   input  logic [31:0] M0_DAT_i,
   output logic [31:0] M0_DAT_o,
   output logic        M0_ACK_o,
   input  logic [16:0] M1_ADR_i,
   input  logic        M1_CYC_i,
   input  logic        M1_STB_i,
   input  logic        M1_WE_i,
   input  logic [3:0]  M1_BYTE_STB_i,
   input  logic [31:0] M1_DAT_i,
   output logic [31:0] M1_DAT_o,
   output logic        M1_ACK_o,
   output logic [16:0] WBs_ADR_o,
   output logic        WBs_CYC_o,
   output logic        WBs_STB_o,
   output logic        WBs_WE_o,
   output logic        WBs_RD_o,
   output logic [3:0]  WBs_BYTE_STB_o,
   output logic [31:0] WBs_DAT_o,
   input  logic [31:0] WBs_DAT_i,
   input  logic        WBs_ACK_i,
   output logic [1:0]  Grant_o,
   output logic [1:0]  Timeout_Sts_o,
   input  logic [1:0]  Timeout_Clr_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [7:0] TO_CNT = 8'(TIMEOUT_CYCLES);

   state_t      state_q;
   logic        last_q;
   logic [1:0]  grant_q;
   logic [7:0]  wd_cnt_q;
   logic [7:0]  wd_cnt_d;
   logic [1:0]  tsts_q;
   logic [1:0]  tsts_d;
   logic        gnt0;
   logic        gnt1;
   logic        own_cyc;
   logic        own_stb;
   logic        wd_ack;

   assign gnt0    = (state_q == GNT0);
   assign gnt1    = (state_q == GNT1);
   assign own_cyc = (gnt0 & M0_CYC_i) | (gnt1 & M1_CYC_i);
   assign own_stb = (gnt0 & M0_STB_i) | (gnt1 & M1_STB_i);

   // A real slave ACK on the terminal count takes priority over the watchdog.
   assign wd_ack = own_cyc & own_stb & ~WBs_ACK_i & (wd_cnt_q == TO_CNT);

   // Slave-side mux: selected master passes through, idle bus drives zeros.
   always_comb begin
      WBs_ADR_o      = 17'h0;
      WBs_CYC_o      = 1'b0;
      WBs_STB_o      = 1'b0;
      WBs_WE_o       = 1'b0;
      WBs_BYTE_STB_o = 4'h0;
      WBs_DAT_o      = 32'h0;
      if (gnt0) begin
         WBs_ADR_o      = M0_ADR_i;
         WBs_CYC_o      = M0_CYC_i;
         WBs_STB_o      = M0_STB_i & ~wd_ack;
         WBs_WE_o       = M0_WE_i;
         WBs_BYTE_STB_o = M0_BYTE_STB_i;
         WBs_DAT_o      = M0_DAT_i;
      end else if (gnt1) begin
         WBs_ADR_o      = M1_ADR_i;
         WBs_CYC_o      = M1_CYC_i;
         WBs_STB_o      = M1_STB_i & ~wd_ack;
         WBs_WE_o       = M1_WE_i;
         WBs_BYTE_STB_o = M1_BYTE_STB_i;
         WBs_DAT_o      = M1_DAT_i;
      end
   end

   assign WBs_RD_o = WBs_CYC_o & WBs_STB_o & ~WBs_WE_o;

   // Master returns: only the owner sees ACK/data; watchdog substitutes a marker.
   always_comb begin
      M0_ACK_o = gnt0 & (WBs_ACK_i | wd_ack);
      M1_ACK_o = gnt1 & (WBs_ACK_i | wd_ack);
      M0_DAT_o = gnt0 ? (wd_ack ? TIMEOUT_READ_VALUE : WBs_DAT_i) : 32'h0;
      M1_DAT_o = gnt1 ? (wd_ack ? TIMEOUT_READ_VALUE : WBs_DAT_i) : 32'h0;
   end

   // Watchdog counts stalled strobes; leaving the grant drops CYC, which clears it.
   always_comb begin
      wd_cnt_d = 8'h0;
      if (WBs_CYC_o & WBs_STB_o & ~WBs_ACK_i) wd_cnt_d = wd_cnt_q + 8'h1;
      tsts_d = (tsts_q & ~Timeout_Clr_i) | {gnt1 & wd_ack, gnt0 & wd_ack};
   end

   // Arbitration FSM: round-robin on ties, grant held until owner drops CYC.
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         grant_q <= 2'b00;
      end else begin
         case (state_q)
            IDLE: begin
               if (M0_CYC_i && (!M1_CYC_i || last_q)) begin
                  state_q <= GNT0;
                  grant_q <= 2'b01;
               end else if (M1_CYC_i) begin
                  state_q <= GNT1;
                  grant_q <= 2'b10;
               end
            end
            GNT0: begin
               if (!M0_CYC_i) begin
                  last_q <= 1'b0;
                  if (M1_CYC_i) begin
                     state_q <= GNT1;
                     grant_q <= 2'b10;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end
            GNT1: begin
               if (!M1_CYC_i) begin
                  last_q <= 1'b1;
                  if (M0_CYC_i) begin
                     state_q <= GNT0;
                     grant_q <= 2'b01;
                  end else begin
                     state_q <= IDLE;
                     grant_q <= 2'b00;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= 2'b00;
            end
         endcase
      end
   end

   // Watchdog counter and sticky timeout flags; a set beats a same-cycle clear.
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         wd_cnt_q <= 8'h0;
         tsts_q   <= 2'b00;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         tsts_q   <= tsts_d;
      end
   end

   assign Grant_o       = grant_q;
   assign Timeout_Sts_o = tsts_q;

endmodule

// File: tb/tb_al4s3b_wb_arbiter.sv
// Testbench for al4s3b_wb_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a behavioural model of the arbiter.
module tb_al4s3b_wb_arbiter;

   localparam int          TO  = 16;
   localparam logic [31:0] BAD = 32'hBADFABAC;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] m_adr [2];
   logic        m_cyc [2];
   logic        m_stb [2];
   logic        m_we  [2];
   logic [3:0]  m_bs  [2];
   logic [31:0] m_dat [2];
   logic [31:0] s_dat;
   logic        s_ack;
   logic [1:0]  clr;

   logic [31:0] m0_dat_o, m1_dat_o, wbs_dat_o;
   logic        m0_ack_o, m1_ack_o;
   logic [16:0] wbs_adr_o;
   logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_rd_o;
   logic [3:0]  wbs_bs_o;
   logic [1:0]  grant_o, sts_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   al4s3b_wb_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_READ_VALUE(BAD)) dut (
      .WBs_CLK_i(clk), .WBs_RST_i(rst),
      .M0_ADR_i(m_adr[0]), .M0_CYC_i(m_cyc[0]), .M0_STB_i(m_stb[0]), .M0_WE_i(m_we[0]),
      .M0_BYTE_STB_i(m_bs[0]), .M0_DAT_i(m_dat[0]), .M0_DAT_o(m0_dat_o), .M0_ACK_o(m0_ack_o),
      .M1_ADR_i(m_adr[1]), .M1_CYC_i(m_cyc[1]), .M1_STB_i(m_stb[1]), .M1_WE_i(m_we[1]),
      .M1_BYTE_STB_i(m_bs[1]), .M1_DAT_i(m_dat[1]), .M1_DAT_o(m1_dat_o), .M1_ACK_o(m1_ack_o),
      .WBs_ADR_o(wbs_adr_o), .WBs_CYC_o(wbs_cyc_o), .WBs_STB_o(wbs_stb_o), .WBs_WE_o(wbs_we_o),
      .WBs_RD_o(wbs_rd_o), .WBs_BYTE_STB_o(wbs_bs_o), .WBs_DAT_o(wbs_dat_o),
      .WBs_DAT_i(s_dat), .WBs_ACK_i(s_ack),
      .Grant_o(grant_o), .Timeout_Sts_o(sts_o), .Timeout_Clr_i(clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: owner is -1 (nobody), 0 or 1; stall counts strobed cycles.
   int          owner, last, stall;
   logic [1:0]  sts;
   logic [1:0]  e_grant;
   logic        e_cyc, e_stb, e_we, e_rd, e_wd;
   logic [16:0] e_adr;
   logic [3:0]  e_bs;
   logic [31:0] e_wdat;
   logic        e_ack [2];
   logic [31:0] e_dat [2];
   logic        o_ack [2];
   logic [31:0] o_dat [2];
   logic [1:0]  o_grant, o_sts;

   task model_reset();
      owner = -1; last = 1; stall = 0; sts = 2'b00;
   endtask

   task model_eval();
      e_grant = 2'b00; e_cyc = 0; e_stb = 0; e_we = 0; e_rd = 0; e_wd = 0;
      e_adr = '0; e_bs = '0; e_wdat = '0;
      for (int m = 0; m < 2; m++) begin
         e_ack[m] = 0; e_dat[m] = 32'h0;
      end
      if (owner >= 0) begin
         e_wd    = m_cyc[owner] && m_stb[owner] && !s_ack && (stall == TO);
         e_grant = 2'(1 << owner);
         e_cyc   = m_cyc[owner];
         e_stb   = m_stb[owner] && !e_wd;
         e_we    = m_we[owner];
         e_adr   = m_adr[owner];
         e_bs    = m_bs[owner];
         e_wdat  = m_dat[owner];
         e_rd    = e_cyc && e_stb && !e_we;
         e_ack[owner] = s_ack || e_wd;
         e_dat[owner] = e_wd ? BAD : s_dat;
      end
   endtask

   task model_update();
      int nxt;
      if (rst) begin
         model_reset();
      end else begin
         sts = (sts & ~clr) | (e_wd ? 2'(1 << owner) : 2'b00);
         nxt = owner;
         if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) nxt = (last == 1) ? 0 : 1;
            else if (m_cyc[0])        nxt = 0;
            else if (m_cyc[1])        nxt = 1;
         end else if (!m_cyc[owner]) begin
            last = owner;
            nxt  = m_cyc[1 - owner] ? 1 - owner : -1;
         end
         stall = (e_cyc && e_stb && !s_ack) ? stall + 1 : 0;
         owner = nxt;
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge.
   task cycle();
      @(negedge clk);
      model_eval();
      o_ack[0] = m0_ack_o; o_ack[1] = m1_ack_o;
      o_dat[0] = m0_dat_o; o_dat[1] = m1_dat_o;
      o_grant = grant_o; o_sts = sts_o;
      chk("grant", 32'(grant_o), 32'(e_grant));
      chk("s_cyc", 32'(wbs_cyc_o), 32'(e_cyc));
      chk("s_stb", 32'(wbs_stb_o), 32'(e_stb));
      chk("s_we", 32'(wbs_we_o), 32'(e_we));
      chk("s_rd", 32'(wbs_rd_o), 32'(e_rd));
      chk("s_adr", 32'(wbs_adr_o), 32'(e_adr));
      chk("s_bs", 32'(wbs_bs_o), 32'(e_bs));
      chk("s_wdat", wbs_dat_o, e_wdat);
      chk("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
      chk("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
      chk("m0_dat", m0_dat_o, e_dat[0]);
      chk("m1_dat", m1_dat_o, e_dat[1]);
      chk("sts", 32'(sts_o), 32'(sts));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task idle_inputs();
      for (int m = 0; m < 2; m++) begin
         m_cyc[m] = 0; m_stb[m] = 0; m_we[m] = 0;
         m_adr[m] = '0; m_bs[m] = 4'hF; m_dat[m] = '0;
      end
      s_ack = 0; s_dat = '0; clr = 2'b00;
   endtask

   task timeout_run(input int ack_cycle, input logic [31:0] sdata,
                    output int ack_at, output logic [31:0] adat);
      m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 0; m_adr[0] = 17'h00010;
      s_ack = 0; s_dat = sdata;
      cycle();
      ack_at = -1; adat = '0;
      for (int n = 1; n <= 30; n++) begin
         s_ack = (n == ack_cycle);
         cycle();
         if (o_ack[0]) begin
            ack_at = n; adat = o_dat[0];
            break;
         end
      end
      s_ack = 0; m_cyc[0] = 0; m_stb[0] = 0;
   endtask

   int          acks, bad_gnt, ack_at;
   logic [31:0] adat;
   int          beats [2];
   bit          stall_mode;

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      cycle();
      cycle();
      chk("rst_grant", 32'(o_grant), 32'h0);
      chk("rst_sts", 32'(o_sts), 32'h0);
      rst = 0;

      // Tie round-robin with gapless hand-off: M0, M1, M0.
      m_cyc[0] = 1; m_cyc[1] = 1;
      cycle();
      cycle(); chk("tie_first", 32'(o_grant), 32'h1);
      m_cyc[0] = 0;
      cycle();
      cycle(); chk("tie_second", 32'(o_grant), 32'h2);
      m_cyc[0] = 1; m_cyc[1] = 0;
      cycle();
      cycle(); chk("tie_third", 32'(o_grant), 32'h1);
      idle_inputs();
      cycle();
      cycle(); chk("tie_idle", 32'(o_grant), 32'h0);

      // Single master read with a one-cycle slave wait.
      m_cyc[0] = 1; m_stb[0] = 1; m_adr[0] = 17'h00000;
      cycle();
      cycle(); chk("single_grant", 32'(o_grant), 32'h1);
      s_ack = 1; s_dat = 32'h12345678;
      cycle();
      chk("single_ack", 32'(o_ack[0]), 32'h1);
      chk("single_dat", o_dat[0], 32'h12345678);
      chk("single_m1ack", 32'(o_ack[1]), 32'h0);
      idle_inputs();
      cycle();
      cycle(); chk("single_idle", 32'(o_grant), 32'h0);

      // Grant hold: M1 runs 4 beats while M0 waits.
      m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 1; m_dat[1] = 32'hA5A5_0001;
      cycle();
      m_cyc[0] = 1; m_stb[0] = 1; s_ack = 1;
      acks = 0; bad_gnt = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (o_ack[1]) acks++;
         if (o_grant != 2'b10) bad_gnt++;
      end
      chk("hold_acks", 32'(acks), 32'd4);
      chk("hold_grant", 32'(bad_gnt), 32'd0);
      m_cyc[1] = 0; m_stb[1] = 0; s_ack = 0;
      cycle();
      cycle(); chk("hold_handoff", 32'(o_grant), 32'h1);
      idle_inputs();
      cycle();
      cycle();

      // Watchdog timeout on a never-acknowledged read.
      timeout_run(-1, 32'h0, ack_at, adat);
      chk("to_latency", 32'(ack_at), 32'd17);
      chk("to_data", adat, BAD);
      cycle(); chk("to_sts_set", 32'(o_sts), 32'h1);
      clr = 2'b01;
      cycle();
      clr = 2'b00;
      cycle(); chk("to_sts_clr", 32'(o_sts), 32'h0);

      // Real ACK exactly on the terminal count wins.
      timeout_run(17, 32'hCAFE0001, ack_at, adat);
      chk("tc_latency", 32'(ack_at), 32'd17);
      chk("tc_data", adat, 32'hCAFE0001);
      cycle();
      cycle(); chk("tc_sts", 32'(o_sts), 32'h0);

      // Asynchronous reset in the middle of an M1 beat.
      m_cyc[1] = 1; m_stb[1] = 1; m_we[1] = 0;
      cycle();
      cycle();
      s_ack = 1;
      #1;
      chk("pre_rst_ack", 32'(m1_ack_o), 32'h1);
      rst = 1;
      model_reset();
      #1;
      chk("arst_grant", 32'(grant_o), 32'h0);
      chk("arst_cyc", 32'(wbs_cyc_o), 32'h0);
      chk("arst_m1ack", 32'(m1_ack_o), 32'h0);
      chk("arst_m0ack", 32'(m0_ack_o), 32'h0);
      idle_inputs();
      cycle();
      rst = 0;
      m_cyc[0] = 1; m_cyc[1] = 1;
      cycle();
      cycle(); chk("arst_tie", 32'(o_grant), 32'h1);
      idle_inputs();
      cycle();
      cycle();

      // Randomized traffic, with occasional stalled-slave phases to hit the watchdog.
      beats[0] = 0; beats[1] = 0; stall_mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 150 == 0) stall_mode = ($urandom_range(0, 2) == 0);
         for (int m = 0; m < 2; m++) begin
            if (!m_cyc[m]) begin
               if ($urandom_range(0, 3) == 0) begin
                  m_cyc[m] = 1; beats[m] = $urandom_range(1, 4);
               end
            end else if ($urandom_range(0, 60) == 0) begin
               m_cyc[m] = 0;
            end
            m_stb[m] = m_cyc[m] && (stall_mode || $urandom_range(0, 4) != 0);
            m_we[m]  = 1'($urandom);
            m_adr[m] = 17'($urandom);
            m_bs[m]  = 4'($urandom);
            m_dat[m] = $urandom;
         end
         s_ack = !stall_mode && ($urandom_range(0, 2) == 0);
         s_dat = $urandom;
         clr   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         cycle();
         for (int m = 0; m < 2; m++) begin
            if (m_cyc[m] && e_ack[m]) begin
               beats[m]--;
               if (beats[m] <= 0) m_cyc[m] = 0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/al4s3b_wb_arbiter.md
# al4s3b_wb_arbiter

Two-master Wishbone arbiter that shares the single FPGA Wishbone slave port (the register and QL-reserved aperture) between the AHB-to-FPGA bridge (master 0) and a local fabric master such as a sequencer or DMA (master 1). It uses round-robin arbitration and holds each grant for a full cycle (CYC high to CYC low). A bus-timeout watchdog completes any transfer the slave never acknowledges, so neither master can hang. The block sits between the masters and the FPGA IP top level and has no internal registers visible on the bus.

## Interface
- TIMEOUT_CYCLES, 16: slave-side STB cycles without ACK before the watchdog completes the transfer; legal range 2–255.
- TIMEOUT_READ_VALUE, 32'hBAD_FAB_AC: read data returned on a timed-out transfer.
- WBs_CLK_i  in  1  sole clock, rising edge.
- WBs_RST_i  in  1  asynchronous, active-high reset.
- M0_ADR_i / M1_ADR_i  in  17  master address.
- M0_CYC_i / M1_CYC_i  in  1  cycle request; this signal is also the arbitration request.
- M0_STB_i / M1_STB_i  in  1  transfer strobe.
- M0_WE_i / M1_WE_i  in  1  write enable.
- M0_BYTE_STB_i / M1_BYTE_STB_i  in  4  byte enables.
- M0_DAT_i / M1_DAT_i  in  32  write data.
- M0_DAT_o / M1_DAT_o  out  32  read data.
- M0_ACK_o / M1_ACK_o  out  1  acknowledge.
- WBs_ADR_o, WBs_CYC_o, WBs_STB_o, WBs_WE_o, WBs_RD_o, WBs_BYTE_STB_o, WBs_DAT_o  out  17/1/1/1/1/4/32  slave-side bus.
- WBs_DAT_i  in  32  slave read data.
- WBs_ACK_i  in  1  slave acknowledge.
- Grant_o  out  2  one-hot current grant; 2'b00 when idle.
- Timeout_Sts_o  out  2  sticky timeout flag per master.
- Timeout_Clr_i  in  2  per-bit clear of Timeout_Sts_o.

## Operation
- State machine states:
  - IDLE: no grant.
  - GNT0: master 0 owns the slave.
  - GNT1: master 1 owns the slave.
- Transitions:
  - IDLE with exactly one CYC high goes to that master's GNT state.
  - IDLE with both CYC high goes to the master not granted last. A `last` register holds the last granted master; its reset value is 1, so master 0 wins the first tie.
  - GNTx with M{x}_CYC_i high stays in GNTx. Multi-beat cycles are never split.
  - GNTx with M{x}_CYC_i low goes to GNTy if M{y}_CYC_i is high, otherwise to IDLE. On leaving, `last` is set to x.
- Slave mux (combinational from the state register):
  - In GNTx: WBs_*_o = M{x} signals, except WBs_STB_o is forced low during a watchdog-ACK cycle. WBs_RD_o = CYC & STB & ~WE.
  - In IDLE: all slave outputs are 0.
- Master returns:
  - Granted master: M{x}_ACK_o = WBs_ACK_i | wd_ack; M{x}_DAT_o = wd_ack ? TIMEOUT_READ_VALUE : WBs_DAT_i.
  - Non-granted master: ACK = 0, DAT = 32'h0.
- Watchdog:
  - 8-bit counter `wd_cnt`, reset value 0.
  - In GNTx, each cycle with WBs_CYC_o & WBs_STB_o & ~WBs_ACK_i & ~wd_ack, `wd_cnt` increments.
  - `wd_cnt` clears on WBs_ACK_i, on wd_ack, on a state change, and whenever STB is low.
  - wd_ack = granted & M{x}_STB_i & (wd_cnt == TIMEOUT_CYCLES); it is a one-cycle pulse.
  - wd_ack sets Timeout_Sts_o[x].
- Simultaneous events:
  - WBs_ACK_i and the terminal count in the same cycle: the real ACK wins; no wd_ack and no status set.
  - Timeout_Clr_i[x] in the same cycle as a set of bit x: the set wins.
- Abort: a granted master that drops CYC mid-transfer releases the bus with no ACK. The counter clears, and the slave sees CYC low in that same cycle.
- Reset: asynchronous and immediate. State goes to IDLE, `last` to 1, `wd_cnt` to 0, Timeout_Sts_o to 0. All outputs go to 0 while reset is held.

## Timing
- Arbitration latency: a CYC asserted in cycle n with the bus idle is granted in cycle n+1, and the slave sees the request in n+1.
- ACK path: combinational slave-to-master, with no added latency once granted.
- Back-to-back masters: the grant moves on the clock edge after the owner drops CYC. There is no IDLE bubble when the other master is waiting.
- Watchdog: with slave STB high from cycle s and no ACK, wd_ack fires in cycle s+TIMEOUT_CYCLES. Slave STB is low in that cycle.
- Grant_o and Timeout_Sts_o are registered. Timeout_Sts_o updates on the edge after wd_ack.

## Test plan
- Single master: M0 reads address 0x00000 with slave ACK one cycle later. Required: Grant_o = 01 from cycle 1; M0_ACK_o in cycle 2 with data 32'h12345678; M1_ACK_o = 0 throughout; IDLE after CYC drops.
- Tie round-robin: M0 and M1 assert CYC together three times. Required: grant order after reset is M0, M1, M0; the grant hand-off is gapless on each CYC drop.
- Grant hold: M1 holds CYC for 4 beats while M0 requests. Required: M0 is not granted until the cycle after M1 drops CYC, and all 4 M1 ACKs pass through.
- Timeout: TIMEOUT_CYCLES = 16, slave never ACKs an M0 read starting at slave cycle 1. Required: M0_ACK_o pulses in cycle 17 with 32'hBAD_FAB_AC; Timeout_Sts_o = 01 next cycle; Timeout_Clr_i = 01 clears it.
- ACK on terminal count: slave ACK lands exactly on the cycle where wd_cnt == 16. Required: slave data is returned and Timeout_Sts_o stays 00.
- Async reset mid-transfer: WBs_RST_i is pulsed while in GNT1 mid-beat. Required: Grant_o, WBs_CYC_o, and the ACK outputs go to 0 without a clock edge; after release, an M0/M1 tie grants M0.
